mw_mem_stage: RTL and testbench

- M-stage consumer of the EX/MEM pipeline register.
- Decodes the M-stage instruction and performs load/store to data memory over a req/ack handshake.
- Freezes the upstream pipeline while a memory access is outstanding.
- Registers the M-stage results into W-stage outputs; this block contains the MEM/WB register.

---
 rtl/mw_mem_stage.sv | 186 ++++++++++++++++++
 tb/tb_mw_mem_stage.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mw_mem_stage.sv
// M-stage load/store unit with the MEM/WB register; freezes upstream while a data access is pending.
// Build option: MEM_ALIGN_CHECK_EN traps misaligned lw/sw/lh/lhu/sh instead of issuing them.
module mw_mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_pc,
  input  logic [31:0] m_instruction,
  input  logic [31:0] m_alu_result,
  input  logic [31:0] m_rt_data,
  output logic        m_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_byteen,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] w_pc,
  output logic [31:0] w_instruction,
  output logic [31:0] w_alu_result,
  output logic [31:0] w_mem_data,
  output logic        w_align_err
);
  localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24,
                         OP_LHU = 6'h25, OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2b;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, load_buf_q, load_buf_d;
  logic [3:0]  byteen_q, byteen_d;
  logic [1:0]  a_q, a_d;

  logic [5:0]  opcode;
  logic [1:0]  a;
  logic        is_load_raw, is_store_raw, align_err, is_load, is_store, is_mem;
  logic [3:0]  st_byteen;
  logic [31:0] st_wdata, ld_value;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign opcode = m_instruction[31:26];
  assign a      = m_alu_result[1:0];

  always_comb begin
    is_load_raw  = 1'b0;
    is_store_raw = 1'b0;
    case (opcode)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: is_load_raw  = 1'b1;
      OP_SB, OP_SH, OP_SW:                 is_store_raw = 1'b1;
      default: ;
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic misaligned;
  always_comb begin
    misaligned = 1'b0;
    case (opcode)
      OP_LW, OP_SW:          misaligned = (a != 2'b00);
      OP_LH, OP_LHU, OP_SH:  misaligned = a[0];
      default: ;
    endcase
  end
  assign align_err = (is_load_raw | is_store_raw) & misaligned;
`else
  assign align_err = 1'b0;
`endif

  assign is_load  = is_load_raw  & ~align_err;
  assign is_store = is_store_raw & ~align_err;
  assign is_mem   = is_load | is_store;
  assign m_stall  = is_mem & (state_q != DONE);

  always_comb begin
    st_byteen = 4'b0000;
    st_wdata  = m_rt_data;
    case (opcode)
      OP_SW: st_byteen = 4'b1111;
      OP_SH: begin
        st_byteen = a[1] ? 4'b1100 : 4'b0011;
        st_wdata  = {2{m_rt_data[15:0]}};
      end
      OP_SB: begin
        st_byteen = 4'b0001 << a;
        st_wdata  = {4{m_rt_data[7:0]}};
      end
      default: ;
    endcase
  end

  // Lane selection uses the address latched with the request, not the live M input.
  assign ld_byte = mem_rdata[{a_q, 3'b000} +: 8];
  assign ld_half = a_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    ld_value = mem_rdata;
    case (opcode)
      OP_LB:  ld_value = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU: ld_value = {24'h0, ld_byte};
      OP_LH:  ld_value = {{16{ld_half[15]}}, ld_half};
      OP_LHU: ld_value = {16'h0, ld_half};
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    byteen_d   = byteen_q;
    wdata_d    = wdata_q;
    a_d        = a_q;
    load_buf_d = load_buf_q;
    case (state_q)
      IDLE: if (is_mem) begin
        state_d  = BUSY;
        req_d    = 1'b1;
        we_d     = is_store;
        addr_d   = {m_alu_result[31:2], 2'b00};
        byteen_d = is_store ? st_byteen : 4'b0000;
        wdata_d  = st_wdata;
        a_d      = a;
      end
      BUSY: if (mem_ack) begin
        state_d    = DONE;
        req_d      = 1'b0;
        load_buf_d = ld_value;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      byteen_q   <= '0;
      wdata_q    <= '0;
      a_q        <= '0;
      load_buf_q <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      byteen_q   <= byteen_d;
      wdata_q    <= wdata_d;
      a_q        <= a_d;
      load_buf_q <= load_buf_d;
    end
  end

  assign mem_req    = req_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_byteen = byteen_q;
  assign mem_wdata  = wdata_q;

  // On a stall the ALU result is left as-is; the cleared instruction already marks the bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_pc          <= '0;
      w_instruction <= '0;
      w_alu_result  <= '0;
      w_mem_data    <= '0;
      w_align_err   <= 1'b0;
    end else if (m_stall) begin
      w_pc          <= '0;
      w_instruction <= '0;
      w_mem_data    <= '0;
      w_align_err   <= 1'b0;
    end else begin
      w_pc          <= m_pc;
      w_instruction <= m_instruction;
      w_alu_result  <= m_alu_result;
      w_mem_data    <= is_load ? load_buf_q : 32'h0;
      w_align_err   <= align_err;
    end
  end
endmodule

// File: tb/tb_mw_mem_stage.sv
// Randomized self-checking bench for mw_mem_stage against a behavioural load/store model.
module tb_mw_mem_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m_pc, m_instruction, m_alu_result, m_rt_data;
  logic        m_stall, mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_byteen;
  logic [31:0] w_pc, w_instruction, w_alu_result, w_mem_data;
  logic        w_align_err;

  int vectors = 0;
  int miscompares = 0;

  mw_mem_stage dut (
    .clk(clk), .reset(reset), .m_pc(m_pc), .m_instruction(m_instruction),
    .m_alu_result(m_alu_result), .m_rt_data(m_rt_data), .m_stall(m_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_byteen(mem_byteen),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .w_pc(w_pc),
    .w_instruction(w_instruction), .w_alu_result(w_alu_result), .w_mem_data(w_mem_data),
    .w_align_err(w_align_err)
  );

  always #5 clk = ~clk;

  function automatic bit f_is_load(input logic [5:0] op);
    return op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
  endfunction

  function automatic bit f_is_store(input logic [5:0] op);
    return op inside {6'h28, 6'h29, 6'h2b};
  endfunction

  function automatic bit f_align_err(input logic [5:0] op, input logic [1:0] a);
`ifdef MEM_ALIGN_CHECK_EN
    if (op == 6'h23 || op == 6'h2b) return a != 2'b00;
    if (op == 6'h21 || op == 6'h25 || op == 6'h29) return a[0];
    return 1'b0;
`else
    return (op == 6'h3f) && (a == 2'b11) && 1'b0;
`endif
  endfunction

  function automatic logic [3:0] f_byteen(input logic [5:0] op, input logic [1:0] a);
    case (op)
      6'h2b:   return 4'hF;
      6'h29:   return a[1] ? 4'hC : 4'h3;
      6'h28:   return 4'(1 << int'(a));
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [31:0] f_wdata(input logic [5:0] op, input logic [31:0] rt);
    case (op)
      6'h29:   return {2{rt[15:0]}};
      6'h28:   return {4{rt[7:0]}};
      default: return rt;
    endcase
  endfunction

  function automatic logic [31:0] f_load(input logic [5:0] op, input logic [1:0] a, input logic [31:0] rd);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = rd >> (int'(a) * 8);
    b  = sh[7:0];
    h  = a[1] ? rd[31:16] : rd[15:0];
    case (op)
      6'h20:   return 32'($signed(b));
      6'h24:   return 32'(b);
      6'h21:   return 32'($signed(h));
      6'h25:   return 32'(h);
      default: return rd;
    endcase
  endfunction

  // Drives one instruction through M and checks stall, request, bubble and W-capture behaviour.
  task automatic run_instr(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] alu,
                           input logic [31:0] rt, input int wait_n, input logic [31:0] rdata);
    logic [5:0]  op;
    bit          aerr, ld, st, mem;
    logic [31:0] exp_md;
    op   = instr[31:26];
    aerr = f_align_err(op, alu[1:0]);
    ld   = f_is_load(op) && !aerr;
    st   = f_is_store(op) && !aerr;
    mem  = ld || st;
    exp_md = ld ? f_load(op, alu[1:0], rdata) : 32'h0;
    m_pc = pc; m_instruction = instr; m_alu_result = alu; m_rt_data = rt; mem_ack = 1'b0;
    #1;
    vectors++;
    if (m_stall !== mem) begin
      miscompares++; $display("FAIL stall_idle instr=%h got=%b exp=%b", instr, m_stall, mem);
    end
    vectors++;
    if (mem_req !== 1'b0) begin
      miscompares++; $display("FAIL req_idle instr=%h got=%b exp=0", instr, mem_req);
    end
    if (mem) begin
      for (int i = 0; i <= wait_n; i++) begin
        @(negedge clk);
        vectors++;
        if (mem_req !== 1'b1 || m_stall !== 1'b1 || w_instruction !== 32'h0 || w_pc !== 32'h0) begin
          miscompares++;
          $display("FAIL busy instr=%h got req=%b stall=%b w_instr=%h w_pc=%h exp req=1 stall=1 w=0",
                   instr, mem_req, m_stall, w_instruction, w_pc);
        end
        if (i == 0) begin
          vectors++;
          if (mem_addr !== {alu[31:2], 2'b00} || mem_we !== st || mem_byteen !== f_byteen(op, alu[1:0])) begin
            miscompares++;
            $display("FAIL req_fields instr=%h got addr=%h we=%b be=%b exp addr=%h we=%b be=%b", instr,
                     mem_addr, mem_we, mem_byteen, {alu[31:2], 2'b00}, st, f_byteen(op, alu[1:0]));
          end
          if (st) begin
            vectors++;
            if (mem_wdata !== f_wdata(op, rt)) begin
              miscompares++;
              $display("FAIL wdata instr=%h got=%h exp=%h", instr, mem_wdata, f_wdata(op, rt));
            end
          end
        end
        if (i == wait_n) begin
          mem_ack = 1'b1; mem_rdata = rdata;
        end else begin
          mem_rdata = $urandom;
        end
      end
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = $urandom;
      vectors++;
      if (m_stall !== 1'b0 || mem_req !== 1'b0) begin
        miscompares++;
        $display("FAIL done instr=%h got stall=%b req=%b exp 0 0", instr, m_stall, mem_req);
      end
    end
    @(negedge clk);
    vectors++;
    if (w_pc !== pc || w_instruction !== instr || w_alu_result !== alu) begin
      miscompares++;
      $display("FAIL w_capture got pc=%h ins=%h alu=%h exp pc=%h ins=%h alu=%h",
               w_pc, w_instruction, w_alu_result, pc, instr, alu);
    end
    vectors++;
    if (w_mem_data !== exp_md || w_align_err !== aerr) begin
      miscompares++;
      $display("FAIL w_mem instr=%h addr=%h got data=%h err=%b exp data=%h err=%b",
               instr, alu, w_mem_data, w_align_err, exp_md, aerr);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ack = 1'b0; mem_rdata = 32'h0;
    m_pc = 32'h0; m_instruction = 32'h0; m_alu_result = 32'h0; m_rt_data = 32'h0;
    repeat (2) @(negedge clk);
    vectors++;
    if (mem_req !== 1'b0 || m_stall !== 1'b0 || w_pc !== 32'h0 || w_instruction !== 32'h0 ||
        w_alu_result !== 32'h0 || w_mem_data !== 32'h0 || w_align_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset got req=%b stall=%b w_pc=%h w_ins=%h w_alu=%h w_md=%h err=%b exp all 0",
               mem_req, m_stall, w_pc, w_instruction, w_alu_result, w_mem_data, w_align_err);
    end
    reset = 1'b0;
  endtask

  task automatic test_alu_stream();
    for (int i = 0; i < 8; i++)
      run_instr(32'h0040_0000 + 32'(i * 4), {6'h00, 15'($urandom), 11'h021}, $urandom, $urandom, 0, 32'h0);
  endtask

  task automatic test_stores();
    run_instr(32'h0040_1000, {6'h2b, 26'h0012345}, 32'h0000_1004, 32'hDEAD_BEEF, 1, 32'h0);
    run_instr(32'h0040_1004, {6'h28, 26'h0054321}, 32'h0000_1002, 32'h1234_5678, 0, 32'h0);
  endtask

  task automatic test_loads();
    run_instr(32'h0040_2000, {6'h20, 26'h1}, 32'h0000_2003, 32'h0, 0, 32'h80FF_7F01);
    run_instr(32'h0040_2004, {6'h24, 26'h2}, 32'h0000_2003, 32'h0, 2, 32'h80FF_7F01);
    run_instr(32'h0040_2008, {6'h21, 26'h3}, 32'h0000_2002, 32'h0, 1, 32'h80FF_7F01);
    run_instr(32'h0040_200c, {6'h25, 26'h4}, 32'h0000_2002, 32'h0, 0, 32'h80FF_7F01);
  endtask

  task automatic test_align();
    run_instr(32'h0040_3000, {6'h23, 26'h5}, 32'h0000_3002, 32'h0, 0, 32'hCAFE_F00D);
  endtask

  task automatic test_random();
    logic [5:0] ops [10];
    ops = '{6'h00, 6'h09, 6'h23, 6'h21, 6'h25, 6'h20, 6'h24, 6'h2b, 6'h29, 6'h28};
    for (int i = 0; i < 60; i++)
      run_instr($urandom, {ops[$urandom_range(0, 9)], 26'($urandom)}, $urandom, $urandom,
                int'($urandom_range(0, 3)), $urandom);
  endtask

  task automatic test_reset_mid_busy();
    m_pc = 32'h0040_5000; m_instruction = {6'h2b, 26'h7}; m_alu_result = 32'h0000_5000;
    m_rt_data = 32'h1111_2222; mem_ack = 1'b0;
    @(negedge clk);
    vectors++;
    if (mem_req !== 1'b1) begin
      miscompares++; $display("FAIL rst_busy_req got=%b exp=1", mem_req);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (mem_req !== 1'b0 || w_pc !== 32'h0 || w_instruction !== 32'h0 || w_alu_result !== 32'h0 ||
        w_mem_data !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_async got req=%b w_pc=%h w_ins=%h w_alu=%h w_md=%h exp all 0",
               mem_req, w_pc, w_instruction, w_alu_result, w_mem_data);
    end
    @(negedge clk);
    m_pc = 32'h0; m_instruction = 32'h0; m_alu_result = 32'h0; m_rt_data = 32'h0;
    reset = 1'b0;
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    vectors++;
    if (mem_req !== 1'b0 || m_stall !== 1'b0 || w_instruction !== 32'h0 || w_mem_data !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_late_ack got req=%b stall=%b w_ins=%h w_md=%h exp all 0",
               mem_req, m_stall, w_instruction, w_mem_data);
    end
  endtask

  initial begin
    test_reset();
    test_alu_stream();
    test_stores();
    test_loads();
    test_align();
    test_random();
    test_reset_mid_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
